// File: rtl/aer_rx_dualrail.sv
// AER dual-rail link receiver.
// Synchronises the sender's bit0/bit1/Dt rails and runs the four-phase handshake:
// one ack per address bit and one senack per end-of-event token. Complete
// ADDR_W-bit addresses (MSB first) are offered downstream on a valid/ready port
// with a single-entry buffer.
module aer_rx_dualrail #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit0,
    input  logic              bit1,
    input  logic              Dt,
    output logic              ack,
    output logic              senack,
    output logic [ADDR_W-1:0] ev_addr,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic              err
);

    localparam int CNT_W = $clog2(ADDR_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_W);
    // The abort fires on the edge where the timer would reach TIMEOUT,
    // so ack/senack fall exactly TIMEOUT cycles after they rose.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ACKB    = 2'd1,
        ACKD    = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t            state_r;
    logic [2:0]        sync_r [SYNC_STAGES];
    logic [2:0]        prev_r;
    logic [ADDR_W-1:0] shift_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [7:0]        timer_r;

    logic [2:0] vec_s;
    logic       stable_s;
    logic       idle_s;
    logic       rail_s;
    logic       tok_s;
    logic       cnt_full_s;
    logic       slot_free_s;
    logic       shift_go_s;
    logic       load_go_s;
    logic       proto_err_s;
    logic       timeout_s;

    // Synchroniser chain on {Dt,bit1,bit0} plus previous-value register for the stability qualifier
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 3'b000;
            end
            prev_r <= 3'b000;
        end else begin
            sync_r[0] <= {Dt, bit1, bit0};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // A vector is only acted on once it has held for two consecutive cycles
    assign vec_s       = sync_r[SYNC_STAGES-1];
    assign stable_s    = (vec_s == prev_r);
    assign idle_s      = stable_s && (vec_s == 3'b000);
    assign rail_s      = stable_s && ((vec_s == 3'b001) || (vec_s == 3'b010));
    assign tok_s       = stable_s && (vec_s == 3'b100);
    assign cnt_full_s  = (cnt_r == CNT_FULL);
    assign slot_free_s = !ev_valid || ev_ready;
    assign shift_go_s  = rail_s && !cnt_full_s;
    assign load_go_s   = tok_s && cnt_full_s && slot_free_s;
    // Both rails, token together with a rail, early token, or a bit beyond the address width
    assign proto_err_s = stable_s && ((vec_s == 3'b011)
                                   || (vec_s[2] && (vec_s[1] || vec_s[0]))
                                   || (tok_s && !cnt_full_s)
                                   || (rail_s && cnt_full_s));
    assign timeout_s   = (timer_r == TMO_LAST);

    // Handshake FSM, address assembly and single-entry output buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= COLLECT;
            ack      <= 1'b0;
            senack   <= 1'b0;
            err      <= 1'b0;
            ev_valid <= 1'b0;
            ev_addr  <= '0;
            shift_r  <= '0;
            cnt_r    <= '0;
            timer_r  <= 8'd0;
        end else begin
            err <= 1'b0;
            // Downstream handshake frees the slot; a same-cycle reload below wins
            if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
            case (state_r)
                COLLECT: begin
                    if (shift_go_s) begin
                        shift_r <= {shift_r[ADDR_W-2:0], vec_s[1]};
                        cnt_r   <= cnt_r + CNT_W'(1);
                        ack     <= 1'b1;
                        timer_r <= 8'd0;
                        state_r <= ACKB;
                    end else if (load_go_s) begin
                        ev_addr  <= shift_r;
                        ev_valid <= 1'b1;
                        senack   <= 1'b1;
                        timer_r  <= 8'd0;
                        state_r  <= ACKD;
                    end else if (proto_err_s) begin
                        ack     <= 1'b0;
                        senack  <= 1'b0;
                        shift_r <= '0;
                        cnt_r   <= '0;
                        err     <= 1'b1;
                        state_r <= ERR;
                    end else begin
                        // Idle, or token held back until the output slot frees
                        state_r <= COLLECT;
                    end
                end
                ACKB: begin
                    if (idle_s) begin
                        ack     <= 1'b0;
                        state_r <= COLLECT;
                    end else if (timeout_s) begin
                        ack     <= 1'b0;
                        senack  <= 1'b0;
                        shift_r <= '0;
                        cnt_r   <= '0;
                        err     <= 1'b1;
                        state_r <= ERR;
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                ACKD: begin
                    if (idle_s) begin
                        senack  <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= COLLECT;
                    end else if (timeout_s) begin
                        ack     <= 1'b0;
                        senack  <= 1'b0;
                        shift_r <= '0;
                        cnt_r   <= '0;
                        err     <= 1'b1;
                        state_r <= ERR;
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                ERR: begin
                    // Wait for the sender to release all lines before listening again
                    if (idle_s) begin
                        state_r <= COLLECT;
                    end else begin
                        state_r <= ERR;
                    end
                end
                default: begin
                    ack     <= 1'b0;
                    senack  <= 1'b0;
                    state_r <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aer_rx_dualrail.sv
// Directed bench for aer_rx_dualrail: a behavioural four-phase sender drives the
// rails, monitors count handshake edges, error pulses and delivered events.
module tb_aer_rx_dualrail;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit0;
    logic       bit1;
    logic       Dt;
    logic       ev_ready;
    logic       ack;
    logic       senack;
    logic       ev_valid;
    logic       err;
    logic [3:0] ev_addr;

    int total = 0;
    int bad   = 0;

    int cyc          = 0;
    int ack_rises    = 0;
    int senack_rises = 0;
    int err_rises    = 0;
    int err_cycles   = 0;
    int valid_cycles = 0;
    int ack_rise_cyc = 0;
    int err_rise_cyc = 0;
    logic ack_p    = 1'b0;
    logic senack_p = 1'b0;
    logic err_p    = 1'b0;
    logic [3:0] rx_q[$];

    int a0, s0, e0, ec0, v0, r0;

    aer_rx_dualrail #(
        .ADDR_W     (4),
        .SYNC_STAGES(2),
        .TIMEOUT    (255)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bit0    (bit0),
        .bit1    (bit1),
        .Dt      (Dt),
        .ack     (ack),
        .senack  (senack),
        .ev_addr (ev_addr),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Edge and pulse monitors, sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ack === 1'b1 && ack_p === 1'b0) begin
            ack_rises    = ack_rises + 1;
            ack_rise_cyc = cyc;
        end
        if (senack === 1'b1 && senack_p === 1'b0) senack_rises = senack_rises + 1;
        if (err === 1'b1 && err_p === 1'b0) begin
            err_rises    = err_rises + 1;
            err_rise_cyc = cyc;
        end
        if (err === 1'b1) err_cycles = err_cycles + 1;
        if (ev_valid === 1'b1) valid_cycles = valid_cycles + 1;
        ack_p    = ack;
        senack_p = senack;
        err_p    = err;
    end

    // Record every downstream transfer
    always @(posedge clk) begin
        if (ev_valid === 1'b1 && ev_ready === 1'b1) rx_q.push_back(ev_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sel: 0=ack 1=senack 2=err; bounded wait, expiry counts as a failure
    task automatic wait_for(input int sel, input logic val, input int budget, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = (ack === val);
                1:       hit = (senack === val);
                default: hit = (err === val);
            endcase
        end
        check({tag, "_wait"}, 32'(hit), 32'd1);
    endtask

    task automatic send_bit(input logic b);
        bit1 = b;
        bit0 = ~b;
        wait_for(0, 1'b1, 40, "ack_up");
        bit1 = 1'b0;
        bit0 = 1'b0;
        wait_for(0, 1'b0, 40, "ack_dn");
    endtask

    task automatic send_addr(input logic [3:0] a);
        for (int i = 3; i >= 0; i--) send_bit(a[i]);
        Dt = 1'b1;
        wait_for(1, 1'b1, 40, "senack_up");
        Dt = 1'b0;
        wait_for(1, 1'b0, 40, "senack_dn");
    endtask

    task automatic snap();
        a0  = ack_rises;
        s0  = senack_rises;
        e0  = err_rises;
        ec0 = err_cycles;
        v0  = valid_cycles;
        r0  = rx_q.size();
    endtask

    initial begin
        reset = 1'b1; bit0 = 1'b0; bit1 = 1'b1; Dt = 1'b0; ev_ready = 1'b0;

        // T1: reset with toggling rails
        repeat (3) begin
            @(negedge clk);
            bit0 = ~bit0; bit1 = ~bit1; Dt = ~Dt;
        end
        @(negedge clk);
        check("t1_ack", 32'(ack), 32'd0);
        check("t1_senack", 32'(senack), 32'd0);
        check("t1_valid", 32'(ev_valid), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_addr", 32'(ev_addr), 32'd0);
        bit0 = 1'b0; bit1 = 1'b0; Dt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // T2: event 4'hA with ready held high
        ev_ready = 1'b1;
        snap();
        send_addr(4'hA);
        repeat (3) @(negedge clk);
        check("t2_acks", 32'(ack_rises - a0), 32'd4);
        check("t2_senacks", 32'(senack_rises - s0), 32'd1);
        check("t2_rxcount", 32'(rx_q.size() - r0), 32'd1);
        check("t2_addr", 32'(rx_q[r0]), 32'hA);
        check("t2_validcyc", 32'(valid_cycles - v0), 32'd1);
        check("t2_err", 32'(err_rises - e0), 32'd0);

        // T3: back-pressure, second token held until ready
        ev_ready = 1'b0;
        snap();
        send_addr(4'h3);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        Dt = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_senack_held", 32'(senack), 32'd0);
        check("t3_senacks", 32'(senack_rises - s0), 32'd1);
        check("t3_valid", 32'(ev_valid), 32'd1);
        check("t3_addr_hold", 32'(ev_addr), 32'h3);
        ev_ready = 1'b1;
        wait_for(1, 1'b1, 40, "t3_senack_up");
        Dt = 1'b0;
        wait_for(1, 1'b0, 40, "t3_senack_dn");
        repeat (3) @(negedge clk);
        check("t3_rxcount", 32'(rx_q.size() - r0), 32'd2);
        check("t3_first", 32'(rx_q[r0]), 32'h3);
        check("t3_second", 32'(rx_q[r0+1]), 32'hC);
        check("t3_valid_end", 32'(ev_valid), 32'd0);

        // T4: both rails high after two bits, then recovery with 4'h5
        snap();
        send_bit(1'b1); send_bit(1'b0);
        bit0 = 1'b1; bit1 = 1'b1;
        wait_for(2, 1'b1, 40, "t4_err");
        check("t4_ack_low", 32'(ack), 32'd0);
        bit0 = 1'b0; bit1 = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_err_low", 32'(err), 32'd0);
        send_addr(4'h5);
        repeat (3) @(negedge clk);
        check("t4_acks", 32'(ack_rises - a0), 32'd6);
        check("t4_errs", 32'(err_rises - e0), 32'd1);
        check("t4_errcyc", 32'(err_cycles - ec0), 32'd1);
        check("t4_rxcount", 32'(rx_q.size() - r0), 32'd1);
        check("t4_addr", 32'(rx_q[r0]), 32'h5);

        // T5: token after three bits, then a clean 4'h9
        snap();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        Dt = 1'b1;
        wait_for(2, 1'b1, 40, "t5_err");
        Dt = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_senacks", 32'(senack_rises - s0), 32'd0);
        check("t5_rxcount", 32'(rx_q.size() - r0), 32'd0);
        check("t5_valid", 32'(ev_valid), 32'd0);
        check("t5_errs", 32'(err_rises - e0), 32'd1);
        send_addr(4'h9);
        repeat (3) @(negedge clk);
        check("t5_rec_count", 32'(rx_q.size() - r0), 32'd1);
        check("t5_rec_addr", 32'(rx_q[r0]), 32'h9);

        // T6: sender never releases bit1 -> timeout after 255 cycles
        snap();
        bit1 = 1'b1;
        wait_for(0, 1'b1, 40, "t6_ack_up");
        wait_for(2, 1'b1, 400, "t6_err");
        #1;
        check("t6_latency", 32'(err_rise_cyc - ack_rise_cyc), 32'd255);
        check("t6_ack_low", 32'(ack), 32'd0);
        bit1 = 1'b0;
        repeat (6) @(negedge clk);
        send_addr(4'hE);
        repeat (3) @(negedge clk);
        check("t6_rec_count", 32'(rx_q.size() - r0), 32'd1);
        check("t6_rec_addr", 32'(rx_q[r0]), 32'hE);
        check("t6_errs", 32'(err_rises - e0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
